// File: rtl/wb_frame_pkg.sv
// Shared types and bus constants for the Wishbone frame reader.
// The stream word pairs a start-of-frame flag with the fetched data word.
package wb_frame_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;
    localparam logic [3:0] SEL_ALL     = 4'hF;

    typedef struct packed {
        logic        sof;
        logic [31:0] data;
    } pix_word_t;

    localparam int PIX_WORD_W = $bits(pix_word_t);

endpackage

// File: rtl/wshb_if.sv
// Wishbone B4 bus bundle; clock and reset travel with the bus.
// dat_ms is master-to-slave data, dat_sm is slave-to-master data.
interface wshb_if (
    input logic clk,
    input logic rst
);
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;
    logic        stb;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;

    modport master (
        input  clk, rst, dat_sm, ack,
        output adr, dat_ms, sel, we, cyc, stb, cti, bte
    );

    modport slave (
        input  clk, rst, adr, dat_ms, sel, we, cyc, stb, cti, bte,
        output dat_sm, ack
    );
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read: rdata shows the head
// entry whenever empty is low.
module sync_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (do_pop && !do_push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; stale entries are never visible past the pointers.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(push && full));

endmodule

// File: rtl/wb_frame_reader.sv
// Wishbone burst master that sweeps a frame buffer and streams the fetched
// words, tagged with start-of-frame, through a FWFT FIFO.
module wb_frame_reader
    import wb_frame_pkg::*;
#(
    parameter logic [31:0] BASE_ADR    = 32'h0,
    parameter int          FRAME_WORDS = 2048,
    parameter int          BURST_LEN   = 16,
    parameter int          FIFO_DEPTH  = 64
) (
    wshb_if.master        wb_m,
    input  logic          enable,
    output logic [31:0]   pix_data,
    output logic          pix_sof,
    output logic          pix_valid,
    input  logic          pix_ready
);
    localparam int IDX_W  = $clog2(FRAME_WORDS);
    localparam int BEAT_W = $clog2(BURST_LEN);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    localparam logic [IDX_W-1:0]  LAST_IDX    = IDX_W'(FRAME_WORDS - 1);
    localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] PENULT_BEAT = BEAT_W'(BURST_LEN - 2);
    localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0]  BURST_C     = CNT_W'(BURST_LEN);

    logic clk;
    logic rst;

    state_t            state_q;
    logic              cyc_q;
    logic              stb_q;
    logic [2:0]        cti_q;
    logic [31:0]       adr_q;
    logic [IDX_W-1:0]  word_idx_q;
    logic [IDX_W-1:0]  word_idx_d;
    logic [BEAT_W-1:0] beat_q;

    logic              beat_ack;
    logic              room_for_burst;
    pix_word_t         fifo_wdata;
    pix_word_t         fifo_rdata;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;

    assign clk = wb_m.clk;
    assign rst = wb_m.rst;

    assign beat_ack       = (state_q == BURST) && wb_m.ack;
    assign word_idx_d     = (word_idx_q == LAST_IDX) ? '0 : word_idx_q + 1'b1;
    // Only one burst is ever in flight, so the registered count is exact here.
    assign room_for_burst = !fifo_full && ((DEPTH_C - fifo_count) >= BURST_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            cti_q      <= CTI_CLASSIC;
            adr_q      <= BASE_ADR;
            word_idx_q <= '0;
            beat_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (enable && room_for_burst) begin
                        state_q <= BURST;
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        cti_q   <= CTI_INCR;
                        beat_q  <= '0;
                    end
                end
                BURST: begin
                    if (wb_m.ack) begin
                        word_idx_q <= word_idx_d;
                        adr_q      <= BASE_ADR + (32'(word_idx_d) << 2);
                        beat_q     <= beat_q + 1'b1;
                        if (beat_q == LAST_BEAT) begin
                            state_q <= IDLE;
                            cyc_q   <= 1'b0;
                            stb_q   <= 1'b0;
                            cti_q   <= CTI_CLASSIC;
                        end else if (beat_q == PENULT_BEAT) begin
                            cti_q <= CTI_EOB;
                        end else begin
                            cti_q <= CTI_INCR;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cyc_q   <= 1'b0;
                    stb_q   <= 1'b0;
                    cti_q   <= CTI_CLASSIC;
                end
            endcase
        end
    end

    assign wb_m.cyc    = cyc_q;
    assign wb_m.stb    = stb_q;
    assign wb_m.cti    = cti_q;
    assign wb_m.adr    = adr_q;
    assign wb_m.we     = 1'b0;
    assign wb_m.sel    = SEL_ALL;
    assign wb_m.bte    = BTE_LINEAR;
    assign wb_m.dat_ms = '0;

    assign fifo_wdata.sof  = (word_idx_q == '0);
    assign fifo_wdata.data = wb_m.dat_sm;

    sync_fifo #(
        .WIDTH (PIX_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (beat_ack),
        .pop   (fifo_pop),
        .wdata (fifo_wdata),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign pix_valid = !fifo_empty;
    assign fifo_pop  = pix_valid && pix_ready;
    assign pix_data  = fifo_rdata.data;
    assign pix_sof   = fifo_rdata.sof;

endmodule

// File: tb/tb_wb_frame_reader.sv
// Bench for wb_frame_reader: a random-latency slave with a random frame image,
// and a transaction-level scoreboard of expected bus beats and stream words.
module tb_wb_frame_reader;
    import wb_frame_pkg::*;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam int FW = 64;
    localparam int BL = 16;
    localparam int FD = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        enable = 1'b0;
    logic        pix_ready = 1'b0;
    logic        pix_sof;
    logic        pix_valid;
    logic [31:0] pix_data;

    int n_cmp = 0;
    int n_err = 0;

    wshb_if wb (.clk(clk), .rst(rst));

    wb_frame_reader #(
        .BASE_ADR    (BASE),
        .FRAME_WORDS (FW),
        .BURST_LEN   (BL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .wb_m      (wb),
        .enable    (enable),
        .pix_data  (pix_data),
        .pix_sof   (pix_sof),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready)
    );

    always #5 clk = ~clk;

    logic [31:0] mem [FW];
    logic [32:0] exp_q [$];
    int          n_beats = 0;
    int          pop_cnt = 0;
    int          sof_cnt = 0;
    int          ready_mode = 0;
    int          budget = 0;
    int          gap_pct = 0;
    bit          prev_last = 1'b0;
    logic [32:0] first_pop = '0;
    logic [32:0] exp_w;
    logic [31:0] exp_adr;
    logic [2:0]  exp_cti;

    // Slave + scoreboard: everything sampled and driven on the falling edge.
    initial begin
        wb.ack    = 1'b0;
        wb.dat_sm = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                n_beats   = 0;
                pop_cnt   = 0;
                sof_cnt   = 0;
                prev_last = 1'b0;
                wb.ack    = 1'b0;
            end else begin
                case (ready_mode)
                    0:       pix_ready = 1'b0;
                    1:       pix_ready = 1'b1;
                    2:       pix_ready = 1'($urandom_range(0, 1));
                    default: pix_ready = (budget > 0);
                endcase

                n_cmp++;
                if (pix_valid !== (exp_q.size() != 0)) begin
                    n_err++;
                    $display("FAIL pix_valid t=%0t: got %b, want %b", $time, pix_valid, exp_q.size() != 0);
                end
                if (pix_valid === 1'b1 && pix_ready && exp_q.size() != 0) begin
                    exp_w = exp_q.pop_front();
                    n_cmp++;
                    if ({pix_sof, pix_data} !== exp_w) begin
                        n_err++;
                        $display("FAIL stream_word%0d: got sof=%b data=%h, want sof=%b data=%h",
                                 pop_cnt, pix_sof, pix_data, exp_w[32], exp_w[31:0]);
                    end
                    if (pop_cnt == 0) first_pop = {pix_sof, pix_data};
                    if (pix_sof === 1'b1) sof_cnt++;
                    pop_cnt++;
                    if (ready_mode == 3 && budget > 0) budget--;
                end

                if (prev_last) begin
                    n_cmp++;
                    if (wb.cyc !== 1'b0) begin
                        n_err++;
                        $display("FAIL idle_gap t=%0t: cyc=%b after last beat, want 0", $time, wb.cyc);
                    end
                end
                prev_last = 1'b0;

                if (wb.cyc === 1'b1) begin
                    exp_adr = BASE + 32'((n_beats % FW) * 4);
                    exp_cti = ((n_beats % BL) == BL - 1) ? CTI_EOB : CTI_INCR;
                    n_cmp++;
                    if (wb.stb !== 1'b1 || wb.we !== 1'b0 || wb.adr !== exp_adr || wb.cti !== exp_cti) begin
                        n_err++;
                        $display("FAIL bus_beat%0d: stb=%b we=%b adr=%h cti=%b, want stb=1 we=0 adr=%h cti=%b",
                                 n_beats, wb.stb, wb.we, wb.adr, wb.cti, exp_adr, exp_cti);
                    end
                    if ($urandom_range(0, 99) >= gap_pct) begin
                        wb.ack    = 1'b1;
                        wb.dat_sm = mem[n_beats % FW];
                        exp_q.push_back({(n_beats % FW) == 0, mem[n_beats % FW]});
                        if ((n_beats % BL) == BL - 1) prev_last = 1'b1;
                        n_beats++;
                    end else begin
                        wb.ack    = 1'b0;
                        wb.dat_sm = $urandom;
                    end
                end else begin
                    wb.ack = 1'b0;
                    n_cmp++;
                    if (wb.stb !== 1'b0) begin
                        n_err++;
                        $display("FAIL stb_idle t=%0t: stb=%b with cyc=0, want 0", $time, wb.stb);
                    end
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        enable = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || wb.we !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ctrl: cyc=%b stb=%b we=%b, want 0 0 0", wb.cyc, wb.stb, wb.we);
        end
        n_cmp++;
        if (wb.sel !== 4'hF || wb.bte !== 2'b00 || wb.dat_ms !== 32'h0) begin
            n_err++;
            $display("FAIL reset_const: sel=%h bte=%b dat_ms=%h, want F 00 0", wb.sel, wb.bte, wb.dat_ms);
        end
        n_cmp++;
        if (wb.adr !== BASE) begin
            n_err++;
            $display("FAIL reset_adr: got %h, want %h", wb.adr, BASE);
        end
        n_cmp++;
        if (wb.cti !== 3'b000) begin
            n_err++;
            $display("FAIL reset_cti: got %b, want 000", wb.cti);
        end
        n_cmp++;
        if (pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid: got %b, want 0", pix_valid);
        end
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_basic_burst();
        gap_pct = 0;
        ready_mode = 3;
        budget = BL;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 400 && pop_cnt < BL; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (pop_cnt != BL) begin
            n_err++;
            $display("FAIL basic_pops: got %0d words, want %0d", pop_cnt, BL);
        end
        n_cmp++;
        if (first_pop !== {1'b1, mem[0]}) begin
            n_err++;
            $display("FAIL basic_first: got %h, want %h", first_pop, {1'b1, mem[0]});
        end
        n_cmp++;
        if (sof_cnt != 1) begin
            n_err++;
            $display("FAIL basic_sof_count: got %0d, want 1", sof_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_frame_wrap();
        gap_pct = 0;
        ready_mode = 3;
        budget = 200;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 3000 && pop_cnt < 200; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (pop_cnt != 200) begin
            n_err++;
            $display("FAIL wrap_pops: got %0d words, want 200", pop_cnt);
        end
        n_cmp++;
        if (sof_cnt != 4) begin
            n_err++;
            $display("FAIL wrap_sof_count: got %0d, want 4", sof_cnt);
        end
        enable = 1'b0;
    endtask

    task automatic test_backpressure();
        gap_pct = 0;
        ready_mode = 0;
        do_reset();
        enable = 1'b1;
        repeat (300) @(posedge clk);
        #1;
        n_cmp++;
        if (n_beats != FD || exp_q.size() != FD || wb.cyc !== 1'b0) begin
            n_err++;
            $display("FAIL bp_full: beats=%0d queued=%0d cyc=%b, want %0d %0d 0",
                     n_beats, exp_q.size(), wb.cyc, FD, FD);
        end
        budget = BL;
        ready_mode = 3;
        repeat (100) @(posedge clk);
        #1;
        n_cmp++;
        if (pop_cnt != BL || n_beats != FD + BL || wb.cyc !== 1'b0) begin
            n_err++;
            $display("FAIL bp_refill: pops=%0d beats=%0d cyc=%b, want %0d %0d 0",
                     pop_cnt, n_beats, wb.cyc, BL, FD + BL);
        end
        enable = 1'b0;
        ready_mode = 1;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (pop_cnt != FD + BL) begin
            n_err++;
            $display("FAIL bp_drain: got %0d words, want %0d", pop_cnt, FD + BL);
        end
    endtask

    task automatic test_wait_states();
        gap_pct = 30;
        ready_mode = 2;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 2000 && n_beats < 3 * BL; i++) @(posedge clk);
        #1 enable = 1'b0;
        for (int i = 0; i < 2000 && (wb.cyc !== 1'b0 || exp_q.size() != 0); i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_beats < 3 * BL || (n_beats % BL) != 0) begin
            n_err++;
            $display("FAIL ws_beats: got %0d beats, want a whole number of bursts >= %0d", n_beats, 3 * BL);
        end
        n_cmp++;
        if (pop_cnt != n_beats) begin
            n_err++;
            $display("FAIL ws_delivered: got %0d words, want %0d", pop_cnt, n_beats);
        end
        gap_pct = 0;
    endtask

    task automatic test_reset_mid_burst();
        gap_pct = 0;
        ready_mode = 1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 500 && n_beats < BL + 7; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_beats != BL + 7 || wb.cyc !== 1'b1) begin
            n_err++;
            $display("FAIL rmb_reach: beats=%0d cyc=%b, want %0d 1", n_beats, wb.cyc, BL + 7);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (wb.cyc !== 1'b0 || wb.stb !== 1'b0 || pix_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rmb_after: cyc=%b stb=%b valid=%b, want 0 0 0", wb.cyc, wb.stb, pix_valid);
        end
        for (int i = 0; i < 200 && pop_cnt < 1; i++) @(posedge clk);
        #1;
        n_cmp++;
        if (pop_cnt < 1 || first_pop !== {1'b1, mem[0]}) begin
            n_err++;
            $display("FAIL rmb_restart: pops=%0d first=%h, want >=1 %h", pop_cnt, first_pop, {1'b1, mem[0]});
        end
        enable = 1'b0;
    endtask

    task automatic test_enable_toggle();
        int cyc_seen;
        gap_pct = 0;
        ready_mode = 1;
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 200 && n_beats < 3; i++) begin
            @(posedge clk);
            #1;
        end
        enable = 1'b0;
        for (int i = 0; i < 200 && n_beats < BL; i++) begin
            @(posedge clk);
            #1;
        end
        cyc_seen = 0;
        repeat (60) begin
            @(posedge clk);
            #1;
            if (wb.cyc === 1'b1) cyc_seen++;
        end
        n_cmp++;
        if (n_beats != BL || cyc_seen != 0) begin
            n_err++;
            $display("FAIL en_hold: beats=%0d cyc_cycles=%0d, want %0d 0", n_beats, cyc_seen, BL);
        end
        enable = 1'b1;
        for (int i = 0; i < 200 && n_beats < 2 * BL; i++) begin
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (n_beats != 2 * BL) begin
            n_err++;
            $display("FAIL en_resume: got %0d beats, want %0d", n_beats, 2 * BL);
        end
        enable = 1'b0;
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
    endtask

    initial begin
        for (int i = 0; i < FW; i++) mem[i] = $urandom;
        test_reset();
        test_basic_burst();
        test_frame_wrap();
        test_backpressure();
        test_wait_states();
        test_reset_mid_burst();
        test_enable_toggle();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
